// File: rtl/ifu_fetch_responder.sv
// Memory-side responder for IFU single-word fetches and ICACHE 4-word line refills.
// Requests are served one at a time with a programmable latency before the first memory read.
`timescale 1ns/1ps

// state  | meaning
// S_IDLE | sample line_req (priority) / arvalid, latch address and request type
// S_WAIT | burn WAIT_CYCLES idle cycles on a down-counter
// S_READ | mem_en high; 1 beat for a fetch, 4 beats for a line
// S_CAPT | last beat of memory data arrives and is captured
// S_RESP | one-cycle if_access_done or sdram_read_ok pulse
module ifu_fetch_responder #(
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [33:0]  if_axi_data,
   output logic [31:0]  rdata,
   output logic         if_access_done,
   input  logic         line_req,
   input  logic [31:0]  line_addr,
   output logic [127:0] sdram_rdata,
   output logic         sdram_read_ok,
   output logic         mem_en,
   output logic [31:0]  mem_addr,
   input  logic [31:0]  mem_rdata
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_READ,
      S_CAPT,
      S_RESP
   } state_t;

   localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
   localparam bit         HAS_WAIT  = (WAIT_CYCLES > 0);

   state_t      state, state_nxt;
   logic [3:0]  wait_cnt, wait_cnt_nxt;
   logic [1:0]  beat, beat_nxt;
   logic        is_line, line_nxt;
   logic [31:0] req_addr, req_addr_nxt;

   logic        cap_valid;
   logic [1:0]  cap_beat;
   logic        cap_line;

   logic [31:0] araddr;
   logic        arvalid;
   logic        unused_ok;

   assign araddr  = if_axi_data[33:2];
   assign arvalid = if_axi_data[1];

   // rready carries no flow control here; the response pulse fires regardless
   assign unused_ok = ^{if_axi_data[0], araddr[1:0], line_addr[3:0]};

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         wait_cnt <= '0;
         beat     <= '0;
         is_line  <= 1'b0;
         req_addr <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         beat     <= beat_nxt;
         is_line  <= line_nxt;
         req_addr <= req_addr_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      beat_nxt     = beat;
      line_nxt     = is_line;
      req_addr_nxt = req_addr;
      case (state)
         S_IDLE: begin
            if (line_req || arvalid) begin
               line_nxt     = line_req;
               req_addr_nxt = line_req ? {line_addr[31:4], 4'h0} : {araddr[31:2], 2'b00};
               beat_nxt     = '0;
               wait_cnt_nxt = WAIT_LOAD;
               state_nxt    = HAS_WAIT ? S_WAIT : S_READ;
            end
         end
         S_WAIT: begin
            if (wait_cnt == 4'd0) begin
               state_nxt = S_READ;
            end else begin
               wait_cnt_nxt = wait_cnt - 4'd1;
            end
         end
         S_READ: begin
            if (!is_line || beat == 2'd3) begin
               state_nxt = S_CAPT;
            end else begin
               beat_nxt = beat + 2'd1;
            end
         end
         S_CAPT:  state_nxt = S_RESP;
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs are registered from the next-state decode so they line up with the state cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         mem_en         <= 1'b0;
         mem_addr       <= '0;
         cap_valid      <= 1'b0;
         cap_beat       <= '0;
         cap_line       <= 1'b0;
         rdata          <= '0;
         sdram_rdata    <= '0;
         if_access_done <= 1'b0;
         sdram_read_ok  <= 1'b0;
      end else begin
         mem_en <= (state_nxt == S_READ);
         if (state_nxt == S_READ) begin
            mem_addr <= req_addr_nxt + {28'd0, beat_nxt, 2'b00};
         end

         // memory data lags mem_en by one cycle; remember which beat it belongs to
         cap_valid <= mem_en;
         cap_beat  <= beat;
         cap_line  <= is_line;
         if (cap_valid && !cap_line) begin
            rdata <= mem_rdata;
         end
         if (cap_valid && cap_line) begin
            sdram_rdata[{cap_beat, 5'd0} +: 32] <= mem_rdata;
         end

         if_access_done <= (state_nxt == S_RESP) && !line_nxt;
         sdram_read_ok  <= (state_nxt == S_RESP) && line_nxt;
      end
   end

endmodule

// File: tb/tb_ifu_fetch_responder.sv
// Directed bench for ifu_fetch_responder (WAIT_CYCLES=2): reset, fetches, line refill,
// request priority and reset during an in-flight access.
`timescale 1ns/1ps

module tb_ifu_fetch_responder;

   logic         clock = 1'b0;
   logic         reset;
   logic [31:0]  araddr;
   logic         arvalid;
   logic         rready;
   logic [33:0]  if_axi_data;
   logic [31:0]  rdata;
   logic         if_access_done;
   logic         line_req;
   logic [31:0]  line_addr;
   logic [127:0] sdram_rdata;
   logic         sdram_read_ok;
   logic         mem_en;
   logic [31:0]  mem_addr;
   logic [31:0]  mem_rdata = '0;

   assign if_axi_data = {araddr, arvalid, rready};

   ifu_fetch_responder #(.WAIT_CYCLES(2)) dut (
      .clock          (clock),
      .reset          (reset),
      .if_axi_data    (if_axi_data),
      .rdata          (rdata),
      .if_access_done (if_access_done),
      .line_req       (line_req),
      .line_addr      (line_addr),
      .sdram_rdata    (sdram_rdata),
      .sdram_read_ok  (sdram_read_ok),
      .mem_en         (mem_en),
      .mem_addr       (mem_addr),
      .mem_rdata      (mem_rdata)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h3000_0000: return 32'h0000_0413;
         32'h3000_0004: return 32'h00A0_0093;
         32'hA000_0010: return 32'h1111_0000;
         32'hA000_0014: return 32'h2222_0004;
         32'hA000_0018: return 32'h3333_0008;
         32'hA000_001C: return 32'h4444_000C;
         default:       return 32'hBAD0_0000;
      endcase
   endfunction

   always @(posedge clock) begin
      if (mem_en) mem_rdata <= mem_word(mem_addr);
   end

   int           n_assert = 0;
   int           n_fail   = 0;
   int           cyc      = 0;
   int           done_cnt, ok_cnt, both_cnt, done_cyc, ok_cyc;
   logic [31:0]  done_data;
   logic [127:0] ok_data;
   int           en_cyc[$];
   logic [31:0]  en_addr[$];
   int           base;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_log();
      done_cnt  = 0;
      ok_cnt    = 0;
      both_cnt  = 0;
      done_cyc  = -1;
      ok_cyc    = -1;
      done_data = '0;
      ok_data   = '0;
      en_cyc.delete();
      en_addr.delete();
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      cyc++;
      if (if_access_done) begin
         done_cnt++;
         done_cyc  = cyc;
         done_data = rdata;
      end
      if (sdram_read_ok) begin
         ok_cnt++;
         ok_cyc   = cyc;
         ok_data  = sdram_rdata;
         line_req = 1'b0;
      end
      if (if_access_done && sdram_read_ok) both_cnt++;
      if (mem_en) begin
         en_cyc.push_back(cyc);
         en_addr.push_back(mem_addr);
      end
   endtask

   task automatic ticks_to(input int target);
      for (int k = 0; k < 200 && cyc < target; k++) tick();
   endtask

   function automatic int en_c(input int i);
      return (i < en_cyc.size()) ? en_cyc[i] : -1;
   endfunction

   function automatic logic [31:0] en_a(input int i);
      return (i < en_addr.size()) ? en_addr[i] : 32'hFFFF_FFFF;
   endfunction

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_rdata"},       rdata,          128'h0);
      chk({tag, "_sdram_rdata"}, sdram_rdata,    128'h0);
      chk({tag, "_mem_addr"},    mem_addr,       128'h0);
      chk({tag, "_mem_en"},      mem_en,         128'h0);
      chk({tag, "_done"},        if_access_done, 128'h0);
      chk({tag, "_ok"},          sdram_read_ok,  128'h0);
   endtask

   initial begin
      reset     = 1'b0;
      araddr    = 32'h3000_0000;
      arvalid   = 1'b1;
      rready    = 1'b1;
      line_req  = 1'b0;
      line_addr = 32'h0;
      clear_log();

      // reset held with arvalid high
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_outputs_zero("reset_hold");
      end
      chk("reset_no_mem_en", en_cyc.size(), 128'd0);
      chk("reset_no_done", done_cnt, 128'd0);
      arvalid = 1'b0;
      reset   = 1'b1;
      tick();
      tick();

      // single fetch, then back-to-back with arvalid still high
      clear_log();
      base    = cyc;
      araddr  = 32'h3000_0000;
      arvalid = 1'b1;
      tick();
      araddr  = 32'h3000_0004;
      ticks_to(base + 5);
      chk("f1_done_cnt",  done_cnt,  128'd1);
      chk("f1_done_cyc",  done_cyc,  base + 5);
      chk("f1_rdata",     done_data, 128'h0000_0413);
      chk("f1_mem_en_n",  en_cyc.size(), 128'd1);
      chk("f1_mem_en_cyc", en_c(0),  base + 3);
      chk("f1_mem_addr",  en_a(0),   128'h3000_0000);
      tick();
      tick();
      arvalid = 1'b0;
      ticks_to(base + 13);
      chk("b2b_done_cnt",  done_cnt,  128'd2);
      chk("b2b_done_cyc",  done_cyc,  base + 11);
      chk("b2b_rdata",     done_data, 128'h00A0_0093);
      chk("b2b_mem_en_n",  en_cyc.size(), 128'd2);
      chk("b2b_mem_en_cyc", en_c(1),  base + 9);
      chk("b2b_mem_addr",  en_a(1),   128'h3000_0004);
      chk("b2b_rdata_held", rdata,    128'h00A0_0093);
      chk("b2b_no_ok",     ok_cnt,    128'd0);

      // line refill with unaligned address
      clear_log();
      base      = cyc;
      line_addr = 32'hA000_0014;
      line_req  = 1'b1;
      ticks_to(base + 10);
      chk("line_mem_en_n", en_cyc.size(), 128'd4);
      for (int b = 0; b < 4; b++) begin
         chk($sformatf("line_mem_en_cyc%0d", b), en_c(b), base + 3 + b);
         chk($sformatf("line_mem_addr%0d", b), en_a(b), 32'hA000_0010 + 32'(4 * b));
      end
      chk("line_ok_cnt",  ok_cnt,   128'd1);
      chk("line_ok_cyc",  ok_cyc,   base + 8);
      chk("line_data",    ok_data,  128'h4444_000C_3333_0008_2222_0004_1111_0000);
      chk("line_held",    sdram_rdata, 128'h4444_000C_3333_0008_2222_0004_1111_0000);
      chk("line_no_done", done_cnt, 128'd0);

      // simultaneous line_req and arvalid: line first
      clear_log();
      base      = cyc;
      line_addr = 32'hA000_0010;
      line_req  = 1'b1;
      araddr    = 32'h3000_0000;
      arvalid   = 1'b1;
      for (int k = 0; k < 16; k++) begin
         tick();
         if (cyc == base + 10) arvalid = 1'b0;
      end
      chk("prio_ok_cyc",    ok_cyc,   base + 8);
      chk("prio_done_cyc",  done_cyc, base + 14);
      chk("prio_done_cnt",  done_cnt, 128'd1);
      chk("prio_ok_cnt",    ok_cnt,   128'd1);
      chk("prio_first_addr", en_a(0), 128'hA000_0010);
      chk("prio_mem_en_n",  en_cyc.size(), 128'd5);
      chk("prio_fetch_cyc", en_c(4),  base + 12);
      chk("prio_fetch_addr", en_a(4), 128'h3000_0000);
      chk("prio_rdata",     done_data, 128'h0000_0413);
      chk("prio_never_both", both_cnt, 128'd0);

      // reset pulse during WAIT of a fetch
      clear_log();
      base    = cyc;
      araddr  = 32'h3000_0004;
      arvalid = 1'b1;
      tick();
      arvalid = 1'b0;
      reset   = 1'b0;
      #1;
      chk_outputs_zero("wait_rst");
      #1;
      reset = 1'b1;
      for (int k = 0; k < 12; k++) tick();
      chk("wait_rst_no_done",   done_cnt, 128'd0);
      chk("wait_rst_no_mem_en", en_cyc.size(), 128'd0);

      clear_log();
      base    = cyc;
      arvalid = 1'b1;
      tick();
      arvalid = 1'b0;
      ticks_to(base + 8);
      chk("rerun_done_cnt", done_cnt,  128'd1);
      chk("rerun_done_cyc", done_cyc,  base + 5);
      chk("rerun_rdata",    done_data, 128'h00A0_0093);
      chk("rerun_mem_en",   en_c(0),   base + 3);
      chk("rerun_mem_addr", en_a(0),   128'h3000_0004);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
